// File: rtl/uart_pkg.sv
// Shared definitions for the Tiny Tapeout 8N1 UART tile: default divider,
// frame-state encoding and the uio bank bit assignments.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 87;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UIO_RX       = 0;
  localparam int UIO_TX_START = 1;
  localparam int UIO_RX_ACK   = 2;
  localparam int UIO_TX       = 3;
  localparam int UIO_TX_BUSY  = 4;
  localparam int UIO_RX_VALID = 5;
  localparam int UIO_RX_ERR   = 6;
  localparam int UIO_TX_DONE  = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'b1111_1000;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: mid-bit sampling, glitch rejection on the start bit, and
// one-cycle valid / frame-error pulses at the stop-bit sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid_pulse,
  output logic       frame_err_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          arm_q, arm_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          bit_end;

  assign bit_end = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      arm_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      arm_q   <= arm_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // arm_q blocks a new start until the line has been seen idle-high
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    arm_d   = arm_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx) begin
          arm_d = 1'b1;
        end else if (arm_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx) begin
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
            arm_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data            = shift_q;
  assign valid_pulse     = valid_q;
  assign frame_err_pulse = err_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: latches a byte on start, shifts it out LSB first with a
// registered serial output, and pulses done as the stop bit completes.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // tx_d always holds the level for the bit that starts on the next edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (start) begin
          shift_d = data;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: rtl/tt_um_uart_8bit.sv
// Tiny Tapeout tile wrapper: input synchronisers, edge detection, sticky
// RX status flags and the uio bank mapping around the TX/RX cores.
module tt_um_uart_8bit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [2:0] sync1_q, sync2_q;
  logic       start_prev_q, ack_prev_q;
  logic       tx_start_edge, rx_ack_edge;
  logic [7:0] uo_out_q, uo_out_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_err_q, rx_err_d;
  logic       tx_line, tx_busy, tx_done;
  logic [7:0] rx_data;
  logic       rx_valid_pulse, rx_err_pulse;
  logic       unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      start_prev_q <= 1'b0;
      ack_prev_q   <= 1'b0;
      uo_out_q     <= '0;
      rx_valid_q   <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      sync1_q      <= uio_in[2:0];
      sync2_q      <= sync1_q;
      start_prev_q <= sync2_q[UIO_TX_START];
      ack_prev_q   <= sync2_q[UIO_RX_ACK];
      uo_out_q     <= uo_out_d;
      rx_valid_q   <= rx_valid_d;
      rx_err_q     <= rx_err_d;
    end
  end

  assign tx_start_edge = sync2_q[UIO_TX_START] & ~start_prev_q;
  assign rx_ack_edge   = sync2_q[UIO_RX_ACK]   & ~ack_prev_q;

  // A new byte takes priority over a simultaneous ack
  always_comb begin
    uo_out_d   = uo_out_q;
    rx_valid_d = rx_valid_q;
    rx_err_d   = rx_err_q;
    if (rx_valid_pulse) begin
      uo_out_d   = rx_data;
      rx_valid_d = 1'b1;
      rx_err_d   = 1'b0;
    end else begin
      if (rx_ack_edge) begin
        rx_valid_d = 1'b0;
      end
      if (rx_err_pulse) begin
        rx_err_d = 1'b1;
      end
    end
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start_edge),
    .data  (ui_in),
    .tx    (tx_line),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx              (sync2_q[UIO_RX]),
    .data            (rx_data),
    .valid_pulse     (rx_valid_pulse),
    .frame_err_pulse (rx_err_pulse)
  );

  always_comb begin
    uio_out               = '0;
    uio_out[UIO_TX]       = tx_line;
    uio_out[UIO_TX_BUSY]  = tx_busy;
    uio_out[UIO_RX_VALID] = rx_valid_q;
    uio_out[UIO_RX_ERR]   = rx_err_q;
    uio_out[UIO_TX_DONE]  = tx_done;
  end

  assign uo_out = uo_out_q;
  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_uart_8bit.sv
// Randomized self-checking bench for the UART tile; expected line levels and
// RX status come from a frame-level model of the protocol.
module tb_tt_um_uart_8bit;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uio_in;

  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       tx_start_drv = 1'b0;
  logic       ack_drv = 1'b0;
  logic [4:0] junk = 5'h00;

  // model of the receive-side status
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_err = 1'b0;

  int checks = 0;
  int failures = 0;

  assign uio_in = {junk, ack_drv, tx_start_drv, (loop_en ? uio_out[3] : rx_drv)};

  always #5 clk = ~clk;

  tt_um_uart_8bit #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_data"},  {24'd0, uo_out}, {24'd0, exp_data});
    check_eq({tag, "_valid"}, {31'd0, uio_out[5]}, {31'd0, exp_valid});
    check_eq({tag, "_err"},   {31'd0, uio_out[6]}, {31'd0, exp_err});
  endtask

  // Sends one byte and checks every bit centre, busy length and done pulse.
  task automatic send_tx(input logic [7:0] b, input bit retrig);
    logic [9:0] frame;
    int lat;
    int busy_len;
    int done_k;
    int dones;
    bit fell;
    frame = {1'b1, b, 1'b0};
    junk = 5'($urandom);
    ena = 1'($urandom);
    ui_in = b;
    tx_start_drv = 1'b1;
    lat = 0;
    fell = 1'b0;
    while (!fell && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 2) tx_start_drv = 1'b0;
      if (uio_out[3] == 1'b0) fell = 1'b1;
    end
    tx_start_drv = 1'b0;
    check_eq("tx_start_latency_le4", {31'd0, (fell && lat <= 4)}, 32'd1);
    if (!fell) return;
    ui_in = 8'($urandom);
    busy_len = -1;
    done_k = -1;
    dones = 0;
    for (int k = 0; k < 900; k++) begin
      if (k > 0) @(negedge clk);
      if ((k % CPB) == (CPB / 2) && (k / CPB) < 10)
        check_eq($sformatf("tx_bit%0d", k / CPB), {31'd0, uio_out[3]}, {31'd0, frame[k / CPB]});
      if (uio_out[7]) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (busy_len < 0 && !uio_out[4]) busy_len = k;
      if (retrig && k == 300) begin
        tx_start_drv = 1'b1;
        ui_in = 8'($urandom);
      end
    end
    check_eq("tx_busy_cycles", 32'(busy_len), 32'd870);
    check_eq("tx_done_count", 32'(dones), 32'd1);
    check_eq("tx_done_at_end", 32'(done_k), 32'd870);
    if (retrig) begin
      check_eq("tx_no_retrigger_busy", {31'd0, uio_out[4]}, 32'd0);
      check_eq("tx_no_retrigger_line", {31'd0, uio_out[3]}, 32'd1);
      tx_start_drv = 1'b0;
      repeat (4) @(negedge clk);
    end
    $display("tx byte 0x%02h done", b);
  endtask

  task automatic drive_rx(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    junk = 5'($urandom);
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (CPB) @(negedge clk);
    if (stop_ok) begin
      exp_data = b;
      exp_valid = 1'b1;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    $display("rx byte 0x%02h stop=%0d driven", b, stop_ok);
  endtask

  task automatic pulse_ack();
    ack_drv = 1'b1;
    repeat (3) @(negedge clk);
    ack_drv = 1'b0;
    repeat (4) @(negedge clk);
    exp_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_uo_out", {24'd0, uo_out}, 32'h00);
    check_eq("rst_uio_out", {24'd0, uio_out}, 32'h08);
    check_eq("rst_uio_oe", {24'd0, uio_oe}, 32'hF8);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_tx(8'hA5, 1'b0);

    // loopback
    loop_en = 1'b1;
    send_tx(8'h3C, 1'b0);
    exp_data = 8'h3C; exp_valid = 1'b1; exp_err = 1'b0;
    check_rx("loop_3c");
    pulse_ack();
    check_rx("loop_ack");
    send_tx(8'hFF, 1'b0);
    exp_data = 8'hFF; exp_valid = 1'b1; exp_err = 1'b0;
    check_rx("loop_ff");
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      if ($urandom_range(1, 0) == 1) pulse_ack();
      send_tx(b, 1'b0);
      exp_data = b; exp_valid = 1'b1; exp_err = 1'b0;
      check_rx($sformatf("loop_rand%0d", i));
    end
    loop_en = 1'b0;
    repeat (5) @(negedge clk);

    // framing error, then recovery
    drive_rx(8'h55, 1'b0);
    check_rx("ferr_55");
    drive_rx(8'h12, 1'b1);
    check_rx("after_ferr_12");

    // short low pulse on rx is a glitch
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_rx("glitch");

    // start re-pulsed mid-frame and held high past the end
    send_tx(8'($urandom), 1'b1);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(2, 0) == 0) pulse_ack();
      drive_rx(8'($urandom), ($urandom_range(3, 0) != 0));
      check_rx($sformatf("rx_rand%0d", i));
    end

    // reset in the middle of a TX frame
    ui_in = 8'h00;
    tx_start_drv = 1'b1;
    repeat (2) @(negedge clk);
    tx_start_drv = 1'b0;
    repeat (2 + 4 * CPB + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tx", {31'd0, uio_out[3]}, 32'd1);
    check_eq("midrst_busy", {31'd0, uio_out[4]}, 32'd0);
    exp_data = 8'h00; exp_valid = 1'b0; exp_err = 1'b0;
    check_rx("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_tx(8'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
